// File: rtl/uart_device_if.sv
// uart_device_if: CPU device-bus port of the UART.
//   write_enable  - write strobe, already qualified by device id
//   is_control    - access targets the control segment
//   short_address - register select, [3:0] decoded
//   cpu_data_in   - write data
//   cpu_data_out  - combinational read data
// master = CPU side, slave = device side.
interface uart_device_if;
  logic        write_enable;
  logic        is_control;
  logic [7:0]  short_address;
  logic [15:0] cpu_data_in;
  logic [15:0] cpu_data_out;

  modport master (output write_enable, is_control, short_address, cpu_data_in,
                  input  cpu_data_out);
  modport slave  (input  write_enable, is_control, short_address, cpu_data_in,
                  output cpu_data_out);
endinterface

// File: rtl/uart_device.sv
// uart_device: 8N1 UART peripheral on the CPU device bus.
//   cpu_clock - system clock, rising edge
//   reset     - asynchronous, active-high
//   bus       - uart_device_if.slave (register access, control segment only)
//   rx        - serial input (asynchronous, idles high)
//   tx        - serial output (idles high)
// Registers: 0 ID, 1 STATUS, 2 TX, 3 RX, 4 DIV, 5 LOOPBACK (optional).
// Optional feature macro: UART_LOOPBACK_EN (register 5 bit0 routes the
// serializer into the deserializer and parks the tx pin high).

// Circular byte FIFO; pointers carry one extra wrap bit so full/empty
// fall out of the pointer difference.
module uart_device_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   cpu_clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][7:0] mem_q, mem_d;
  logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  push_ok, pop_ok;

  assign count   = wptr_q - rptr_q;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem_q[rptr_q[AW-1:0]];
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) begin
      mem_d[wptr_q[AW-1:0]] = push_data;
      wptr_d                = wptr_q + (AW+1)'(1);
    end
    if (pop_ok) rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

module uart_device #(
  parameter logic [7:0] DEVICE_ID  = 8'h02,
  parameter int         CPU_FREQ   = 10000000,
  parameter int         BAUD       = 115200,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic          cpu_clock,
  input  logic          reset,
  uart_device_if.slave  bus,
  input  logic          rx,
  output logic          tx
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CPU_FREQ / BAUD);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [3:0]  addr;
  logic        wr;
  logic        unused_addr;
  assign addr        = bus.short_address[3:0];
  assign wr          = bus.write_enable && bus.is_control;
  assign unused_addr = ^bus.short_address[7:4];

  // ---- control registers ----
  logic [15:0] divisor_q, divisor_d;
  logic        overrun_q, overrun_d;
  logic        framing_q, framing_d;

  // ---- FIFOs ----
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_head;
  logic [AW:0] tx_count;
  logic        rx_push, rx_pop, rx_full, rx_empty, rx_drop, rx_ferr;
  logic [7:0]  rx_head, rx_shift_q;
  logic [AW:0] unused_rx_count;

  assign tx_push = wr && addr == 4'd2;
  assign rx_pop  = wr && addr == 4'd3;
  // A byte arriving at a full RX FIFO is lost unless the CPU pops this cycle.
  assign rx_drop = rx_push && rx_full && !rx_pop;

  uart_device_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .cpu_clock(cpu_clock), .reset(reset),
    .push(tx_push), .push_data(bus.cpu_data_in[7:0]), .pop(tx_pop),
    .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  uart_device_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .cpu_clock(cpu_clock), .reset(reset),
    .push(rx_push), .push_data(rx_shift_q), .pop(rx_pop),
    .head(rx_head), .count(unused_rx_count), .full(rx_full), .empty(rx_empty)
  );

  // ---- serializer ----
  state_e      tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [7:0]  tx_shift_q;
  logic [2:0]  tx_bit_q;
  logic        tx_q, tx_end, tx_busy;

  assign tx_end  = tx_cnt_q == 16'd0;
  assign tx_busy = tx_state_q != S_IDLE;
  // Byte leaves the FIFO when starting from idle or straight out of a stop bit.
  assign tx_pop  = !tx_empty && (tx_state_q == S_IDLE || (tx_state_q == S_STOP && tx_end));

  // Each bit reloads the counter from divisor_q, so a divisor write lands
  // on the next bit boundary.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      if (tx_busy) tx_cnt_q <= tx_cnt_q - 16'd1;
      case (tx_state_q)
        S_IDLE: if (tx_pop) begin
          tx_state_q <= S_START;
          tx_shift_q <= tx_head;
          tx_cnt_q   <= divisor_q - 16'd1;
          tx_q       <= 1'b0;
        end
        S_START: if (tx_end) begin
          tx_state_q <= S_DATA;
          tx_bit_q   <= '0;
          tx_cnt_q   <= divisor_q - 16'd1;
          tx_q       <= tx_shift_q[0];
        end
        S_DATA: if (tx_end) begin
          tx_cnt_q <= divisor_q - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_q <= S_STOP;
            tx_q       <= 1'b1;
          end else begin
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= tx_bit_q + 3'd1;
            tx_q       <= tx_shift_q[1];
          end
        end
        S_STOP: if (tx_end) begin
          if (tx_pop) begin
            tx_state_q <= S_START;
            tx_shift_q <= tx_head;
            tx_cnt_q   <= divisor_q - 16'd1;
            tx_q       <= 1'b0;
          end else begin
            tx_state_q <= S_IDLE;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---- optional loopback ----
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  logic lb_q, lb_d;
  always_comb begin
    lb_d = lb_q;
    if (wr && addr == 4'd5) lb_d = bus.cpu_data_in[0];
  end
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) lb_q <= 1'b0;
    else       lb_q <= lb_d;
  end
  assign rx_src = lb_q ? tx_q : rx;
  assign tx     = lb_q ? 1'b1 : tx_q;
`else
  assign rx_src = rx;
  assign tx     = tx_q;
`endif

  // ---- deserializer ----
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  state_e      rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic        rx_brk_q, rx_sample;

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_src;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_sample = rx_cnt_q == 16'd0;
  // rx_brk_q marks a bad stop bit already reported: wait for line high only.
  assign rx_push   = rx_state_q == S_STOP && rx_sample && !rx_brk_q &&  rx_s2_q;
  assign rx_ferr   = rx_state_q == S_STOP && rx_sample && !rx_brk_q && !rx_s2_q;

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_brk_q   <= 1'b0;
    end else begin
      if (rx_state_q != S_IDLE && !rx_sample) rx_cnt_q <= rx_cnt_q - 16'd1;
      case (rx_state_q)
        S_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_state_q <= S_START;
          rx_cnt_q   <= (divisor_q >> 1) - 16'd1;
        end
        S_START: if (rx_sample) begin
          if (rx_s2_q) begin
            rx_state_q <= S_IDLE;
          end else begin
            rx_state_q <= S_DATA;
            rx_bit_q   <= '0;
            rx_cnt_q   <= divisor_q - 16'd1;
          end
        end
        S_DATA: if (rx_sample) begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_q   <= divisor_q - 16'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
          else                  rx_bit_q   <= rx_bit_q + 3'd1;
        end
        S_STOP: if (rx_sample) begin
          if (rx_s2_q) begin
            rx_state_q <= S_IDLE;
            rx_brk_q   <= 1'b0;
          end else begin
            rx_brk_q   <= 1'b1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---- register writes ----
  always_comb begin
    divisor_d = divisor_q;
    overrun_d = overrun_q;
    framing_d = framing_q;
    if (wr && addr == 4'd1) begin
      if (bus.cpu_data_in[4]) overrun_d = 1'b0;
      if (bus.cpu_data_in[5]) framing_d = 1'b0;
    end
    if (wr && addr == 4'd4)
      divisor_d = (bus.cpu_data_in < 16'd4) ? 16'd4 : bus.cpu_data_in;
    // A new event wins over a same-cycle clear so it is never lost.
    if (rx_drop) overrun_d = 1'b1;
    if (rx_ferr) framing_d = 1'b1;
  end

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      divisor_q <= DIV_RST;
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
    end else begin
      divisor_q <= divisor_d;
      overrun_q <= overrun_d;
      framing_q <= framing_d;
    end
  end

  // ---- register reads ----
  logic [15:0] rdata;
  always_comb begin
    rdata = '0;
    if (bus.is_control) begin
      case (addr)
        4'd0: rdata = {8'h02, DEVICE_ID};
        4'd1: rdata = {9'b0, tx_busy, framing_q, overrun_q, rx_full, rx_empty, tx_empty, tx_full};
        4'd2: rdata = 16'(tx_count);
        4'd3: rdata = {7'b0, !rx_empty, rx_empty ? 8'h00 : rx_head};
        4'd4: rdata = divisor_q;
`ifdef UART_LOOPBACK_EN
        4'd5: rdata = {15'b0, lb_q};
`endif
        default: rdata = '0;
      endcase
    end
  end
  assign bus.cpu_data_out = rdata;
endmodule

// File: tb/tb_uart_device.sv
// tb_uart_device: randomized self-checking bench for uart_device.
// The reference model describes line traffic as whole frames (start, 8 data
// LSB first, stop) of `div` cycles per bit, and the FIFOs as queues.
module tb_uart_device;
  localparam int CPU_FREQ = 10000000;
  localparam int BAUD     = 115200;
  localparam int DEPTH    = 16;

  logic cpu_clock = 1'b0;
  logic reset     = 1'b1;
  logic rx        = 1'b1;
  logic tx;

  uart_device_if bus();

  uart_device dut (.cpu_clock(cpu_clock), .reset(reset), .bus(bus), .rx(rx), .tx(tx));

  always #5 cpu_clock = ~cpu_clock;

  int cyc = 0;
  always @(posedge cpu_clock) cyc <= cyc + 1;

  // tx pin as seen after each rising edge, indexed by edge count.
  bit txlog [0:65535];
  always @(negedge cpu_clock) txlog[cyc % 65536] <= tx;

  int n_cmp = 0;
  int n_bad = 0;
  int last_wr_cyc;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_mdl_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [15:0] d, input logic ctl = 1'b1);
    @(negedge cpu_clock);
    bus.write_enable  = 1'b1;
    bus.is_control    = ctl;
    bus.short_address = {4'h0, a};
    bus.cpu_data_in   = d;
    @(posedge cpu_clock);
    #1;
    bus.write_enable = 1'b0;
    bus.is_control   = 1'b1;
    last_wr_cyc      = cyc;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [15:0] d, input logic ctl = 1'b1);
    @(negedge cpu_clock);
    bus.write_enable  = 1'b0;
    bus.is_control    = ctl;
    bus.short_address = {4'h0, a};
    #1;
    d = bus.cpu_data_out;
    bus.is_control = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(a, d);
    chk(tag, d, exp);
  endtask

  function automatic logic [15:0] status_exp(input bit txf, input bit txe, input bit rxe,
                                             input bit rxf, input bit ovr, input bit fer,
                                             input bit busy);
    return 16'(txf) | 16'(txe) << 1 | 16'(rxe) << 2 | 16'(rxf) << 3 |
           16'(ovr) << 4 | 16'(fer) << 5 | 16'(busy) << 6;
  endfunction

  // Expected tx level i cycles after the push edge of the first queued frame.
  function automatic bit exp_tx(input int i, input int div);
    int f, b;
    if (i < 1) return 1'b1;
    f = (i - 1) / (10 * div);
    if (f >= tx_exp_q.size()) return 1'b1;
    b = ((i - 1) % (10 * div)) / div;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return tx_exp_q[f][b-1];
  endfunction

  task automatic chk_stream(input string tag, input int e0, input int div, input int ncyc);
    for (int i = 0; i <= ncyc; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(txlog[(e0 + i) % 65536]), 32'(exp_tx(i, div)));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge cpu_clock);
    #1;
    for (int k = 0; k < 10; k++) begin
      rx = f[k];
      repeat (div) @(posedge cpu_clock);
      #1;
    end
    rx = 1'b1;
    repeat (2 * div) @(posedge cpu_clock);
  endtask

  initial begin
    logic [15:0] d;
    int          e0, div, cnt;
    bit          ovr;
    logic [7:0]  b;

    bus.write_enable  = 1'b0;
    bus.is_control    = 1'b1;
    bus.short_address = '0;
    bus.cpu_data_in   = '0;

    // ---- reset values ----
    repeat (3) @(posedge cpu_clock);
    #1 chk("tx_in_reset", 32'(tx), 32'd1);
    @(negedge cpu_clock) reset = 1'b0;
    rd_chk("id", 4'd0, 16'h0202);
    rd_chk("status_rst", 4'd1, status_exp(0, 1, 1, 0, 0, 0, 0));
    rd_chk("div_rst", 4'd4, 16'(CPU_FREQ / BAUD));
    rd_chk("txcnt_rst", 4'd2, 16'h0000);
    rd_chk("rx_rst", 4'd3, 16'h0000);
    rd_chk("reg7", 4'd7, 16'h0000);

    // ---- data segment is invisible ----
    bus_rd(4'd0, d, 1'b0);
    chk("ctl0_read", d, 16'h0000);
    bus_wr(4'd2, 16'h0077, 1'b0);
    rd_chk("ctl0_write", 4'd2, 16'h0000);
    bus_wr(4'd0, 16'hFFFF);
    rd_chk("id_ro", 4'd0, 16'h0202);

    // ---- divisor floor ----
    bus_wr(4'd4, 16'd2);
    rd_chk("div_floor", 4'd4, 16'd4);
    bus_wr(4'd4, 16'd8);
    rd_chk("div_8", 4'd4, 16'd8);

    // ---- single frame A5 with tx_busy tracking ----
    tx_exp_q = '{8'hA5};
    bus_wr(4'd2, 16'h00A5);
    e0 = last_wr_cyc;
    while (cyc < e0 + 84) begin
      bus_rd(4'd1, d);
      chk($sformatf("busy@%0d", cyc - e0), 32'(d[6]), 32'(cyc >= e0 + 1 && cyc <= e0 + 80));
    end
    chk_stream("txA5", e0, 8, 84);

    // ---- random byte at random divisor ----
    div = $urandom_range(4, 12);
    b   = 8'($urandom);
    tx_exp_q = '{b};
    bus_wr(4'd4, 16'(div));
    bus_wr(4'd2, {8'h00, b});
    e0 = last_wr_cyc;
    repeat (10 * div + 6) @(posedge cpu_clock);
    chk_stream("txrnd", e0, div, 10 * div + 4);
    bus_wr(4'd4, 16'd8);

    // ---- TX FIFO fill and drain ----
    // The first byte goes straight to the idle serializer; the rest queue.
    tx_exp_q = {};
    cnt = 0;
    for (int i = 0; i <= 17; i++) begin
      bus_wr(4'd2, 16'(i));
      if (i == 0) begin
        e0 = last_wr_cyc;
        tx_exp_q.push_back(8'(i));
      end else if (cnt < DEPTH) begin
        cnt++;
        tx_exp_q.push_back(8'(i));
      end
      if (i == 16) rd_chk("txfull_16", 4'd1, status_exp(cnt == DEPTH, 0, 1, 0, 0, 0, 1));
    end
    rd_chk("txcnt_full", 4'd2, 16'(cnt));
    while (cyc < e0 + 17 * 80 + 6) @(posedge cpu_clock);
    rd_chk("tx_drained", 4'd1, status_exp(0, 1, 1, 0, 0, 0, 0));
    chk_stream("txfill", e0, 8, 17 * 80 + 4);

    // ---- reset mid-frame ----
    tx_exp_q = '{8'h00};
    bus_wr(4'd2, 16'h0000);
    e0 = last_wr_cyc;
    repeat (12) @(posedge cpu_clock);
    #1 chk("tx_mid", 32'(tx), 32'(exp_tx(cyc - e0, 8)));
    reset = 1'b1;
    #1 chk("tx_abort", 32'(tx), 32'd1);
    repeat (2) @(posedge cpu_clock);
    @(negedge cpu_clock) reset = 1'b0;
    rd_chk("status_abort", 4'd1, status_exp(0, 1, 1, 0, 0, 0, 0));
    rd_chk("div_abort", 4'd4, 16'(CPU_FREQ / BAUD));
    bus_wr(4'd4, 16'd8);

    // ---- RX overrun ----
    rx_mdl_q = {};
    ovr = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 8);
      if (rx_mdl_q.size() < DEPTH) rx_mdl_q.push_back(b);
      else                          ovr = 1'b1;
    end
    rd_chk("rx_overrun", 4'd1, status_exp(0, 1, 0, rx_mdl_q.size() == DEPTH, ovr, 0, 0));
    rd_chk("rx_head", 4'd3, 16'h0100 | 16'(rx_mdl_q[0]));
    bus_wr(4'd1, 16'h0010);
    rd_chk("ovr_clear", 4'd1, status_exp(0, 1, 0, 1, 0, 0, 0));
    while (rx_mdl_q.size() > 0) begin
      rd_chk($sformatf("rx_pop%0d", rx_mdl_q.size()), 4'd3, 16'h0100 | 16'(rx_mdl_q.pop_front()));
      bus_wr(4'd3, 16'h0000);
    end
    rd_chk("rx_empty", 4'd1, status_exp(0, 1, 1, 0, 0, 0, 0));

    // ---- framing error ----
    send_frame(8'($urandom), 1'b0, 8);
    rd_chk("framing", 4'd1, status_exp(0, 1, 1, 0, 0, 1, 0));
    rd_chk("framing_nopush", 4'd3, 16'h0000);
    bus_wr(4'd1, 16'h0020);
    rd_chk("framing_clr", 4'd1, status_exp(0, 1, 1, 0, 0, 0, 0));

    // ---- false start, then receive and pop ----
    @(posedge cpu_clock);
    #1 rx = 1'b0;
    repeat (3) @(posedge cpu_clock);
    #1 rx = 1'b1;
    repeat (40) @(posedge cpu_clock);
    rd_chk("false_start", 4'd1, status_exp(0, 1, 1, 0, 0, 0, 0));
    send_frame(8'h3C, 1'b1, 8);
    rd_chk("rx_3c", 4'd3, 16'h013C);
    bus_wr(4'd3, 16'h0000);
    rd_chk("rx_popped", 4'd3, 16'h0000);
    bus_wr(4'd3, 16'h0000);
    rd_chk("pop_empty", 4'd1, status_exp(0, 1, 1, 0, 0, 0, 0));

`ifdef UART_LOOPBACK_EN
    // ---- loopback ----
    bus_wr(4'd5, 16'h0001);
    rd_chk("lb_reg", 4'd5, 16'h0001);
    bus_wr(4'd2, 16'h005A);
    e0 = last_wr_cyc;
    repeat (12 * 8) @(posedge cpu_clock);
    for (int i = 0; i < 12 * 8; i += 4)
      chk($sformatf("lb_pin[%0d]", i), 32'(txlog[(e0 + i) % 65536]), 32'd1);
    rd_chk("lb_rx", 4'd3, 16'h015A);
    bus_wr(4'd5, 16'h0000);
`else
    bus_wr(4'd5, 16'h0001);
    rd_chk("reg5_absent", 4'd5, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
